mem_access_ctrl: RTL and testbench

Load/store front-end that sits directly upstream of the data memory's port B. It accepts single-word CPU load/store requests, drives the port B address, data and write-enable, and returns captured read data with a done pulse. Addresses in a 16-word I/O window are served locally instead of by memory. The local I/O registers are debounced, edge-latched controller buttons (left/right/start) and a writable LED register.

---
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for data memory port B with a 16-word local I/O window
// holding debounced, edge-latched button registers and an LED register.
module mem_access_ctrl #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] IO_BASE   = 16'hFFF0,
  parameter int               DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we_b,
  output logic [WIDTH-1:0] mem_addr_b,
  output logic [WIDTH-1:0] mem_data_b,
  input  logic [WIDTH-1:0] mem_q_b,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_start,
  output logic [WIDTH-1:0] led
);

  localparam int            CW     = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_rdata;
  logic             r_memWe;
  logic [WIDTH-1:0] r_memAddr;
  logic [WIDTH-1:0] r_memData;
  logic [WIDTH-1:0] r_led;

  logic [3:0]       r_ioOffset;
  logic [WIDTH-1:0] r_wdata;
  logic             r_we;
  logic             r_io;

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_dbLevel;
  logic [CW-1:0]    r_dbCnt [3];
  logic [2:0]       r_press;

  logic [2:0]       w_btnRaw;
  logic             w_ioHit;
  logic [2:0]       w_pressSet;
  logic [2:0]       w_pressClr;
  logic [WIDTH-1:0] w_ioRdata;

  assign w_btnRaw = {btn_start, btn_right, btn_left};
  assign w_ioHit  = (req_addr[WIDTH-1:4] == IO_BASE[WIDTH-1:4]);

  // Level changes only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_dbLevel <= '0;
      for (int i = 0; i < 3; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btnRaw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_dbLevel[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_MAX) begin
          r_dbLevel[i] <= r_sync2[i];
          r_dbCnt[i]   <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pressSet = '0;
    for (int i = 0; i < 3; i++) begin
      w_pressSet[i] = r_sync2[i] & ~r_dbLevel[i] & (r_dbCnt[i] == DB_MAX);
    end
  end

  assign w_pressClr = (r_state == S_ACCESS && r_io && r_we && r_ioOffset == 4'h1)
                      ? r_wdata[2:0] : 3'b000;

  // A press arriving on the same edge as a W1C clear survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press <= '0;
    end else begin
      r_press <= (r_press & ~w_pressClr) | w_pressSet;
    end
  end

  always_comb begin
    w_ioRdata = '0;
    case (r_ioOffset)
      4'h0:    w_ioRdata = {{(WIDTH-3){1'b0}}, r_dbLevel};
      4'h1:    w_ioRdata = {{(WIDTH-3){1'b0}}, r_press};
      4'h2:    w_ioRdata = r_led;
      default: w_ioRdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_led      <= '0;
      r_ioOffset <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_io       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (req) begin
            r_state    <= S_ACCESS;
            r_busy     <= 1'b1;
            r_ioOffset <= req_addr[3:0];
            r_wdata    <= req_wdata;
            r_we       <= req_we;
            r_io       <= w_ioHit;
            // I/O accesses never touch the memory port.
            if (!w_ioHit) begin
              r_memAddr <= req_addr;
              r_memData <= req_wdata;
              r_memWe   <= req_we;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_memWe <= 1'b0;
          if (r_io) begin
            r_rdata <= w_ioRdata;
            if (r_we && r_ioOffset == 4'h2) begin
              r_led <= r_wdata;
            end
          end else if (r_we) begin
            r_rdata <= r_wdata;
          end else begin
            r_rdata <= mem_q_b;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_memWe <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign mem_we_b   = r_memWe;
  assign mem_addr_b = r_memAddr;
  assign mem_data_b = r_memData;
  assign led        = r_led;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table-driven accesses plus
// hand-written back-to-back, debounce, W1C and async-reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        mem_we_b;
  logic [15:0] mem_addr_b;
  logic [15:0] mem_data_b;
  logic [15:0] mem_q_b;
  logic        btn_left;
  logic        btn_right;
  logic        btn_start;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;
  int weCount = 0;

  logic [15:0] mem [256];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp;
    logic        expWe;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] b2bExp [3];

  mem_access_ctrl #(
    .WIDTH    (16),
    .IO_BASE  (16'hFFF0),
    .DB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .mem_we_b  (mem_we_b),
    .mem_addr_b(mem_addr_b),
    .mem_data_b(mem_data_b),
    .mem_q_b   (mem_q_b),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_start (btn_start),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Port B memory model: samples address/data/we on the falling edge.
  always @(negedge clk) begin
    if (mem_we_b) begin
      mem[mem_addr_b[7:0]] = mem_data_b;
      weCount = weCount + 1;
    end
    mem_q_b = mem[mem_addr_b[7:0]];
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // One complete access: request on edge N, completion checked on edge N+1.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic chk, input logic [15:0] exp, input logic expWe,
                               input string name);
    @(negedge clk);
    req       = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    checkOutput({name, "_busy"}, 16'(busy), 16'h1);
    checkOutput({name, "_memWe"}, 16'(mem_we_b), 16'(expWe));
    req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "_done"}, 16'(done), 16'h1);
    checkOutput({name, "_idle"}, 16'(busy), 16'h0);
    checkOutput({name, "_memWeLow"}, 16'(mem_we_b), 16'h0);
    if (chk) checkOutput({name, "_rdata"}, rdata, exp);
  endtask

  task automatic holdCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;
    mem_q_b = 16'h0000;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'hFFF2, 16'h00A5, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    vecs[4] = '{1'b0, 16'hFFF7, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'hFFF0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 16'hFFF5, 16'h1234, 1'b0, 16'h0000, 1'b0};
    b2bExp[0] = 16'h1111;
    b2bExp[1] = 16'h2222;
    b2bExp[2] = 16'h3333;

    reset     = 1'b0;
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_start = 1'b0;
    #2;
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_done", 16'(done), 16'h0);
    checkOutput("rst_memWe", 16'(mem_we_b), 16'h0);
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_led", led, 16'h0000);
    checkOutput("rst_memAddr", mem_addr_b, 16'h0000);
    holdCycles(2);
    reset = 1'b1;
    holdCycles(2);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].chk,
                    vecs[i].exp, vecs[i].expWe, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    checkOutput("io_led", led, 16'h00A5);
    checkOutput("io_weCount", 16'(weCount), 16'h1);
    checkOutput("io_memAddrHeld", mem_addr_b, 16'h0010);
    checkOutput("store_memContents", mem[16], 16'hBEEF);

    // Back-to-back loads with req held high for six cycles.
    req       = 1'b1;
    req_we    = 1'b0;
    req_wdata = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      req_addr = 16'(1 + i / 2);
      @(posedge clk);
      #1;
      if (i % 2 == 0) begin
        checkOutput($sformatf("b2b%0d_busy", i), 16'(busy), 16'h1);
        checkOutput($sformatf("b2b%0d_doneLow", i), 16'(done), 16'h0);
      end else begin
        checkOutput($sformatf("b2b%0d_done", i), 16'(done), 16'h1);
        checkOutput($sformatf("b2b%0d_rdata", i), rdata, b2bExp[i / 2]);
      end
      @(negedge clk);
    end
    req = 1'b0;
    checkOutput("b2b_weCount", 16'(weCount), 16'h1);

    // Short glitch on left must not change the debounced level.
    btn_left = 1'b1;
    holdCycles(3);
    btn_left = 1'b0;
    holdCycles(8);
    applyStimulus(1'b0, 16'hFFF0, 16'h0, 1'b1, 16'h0000, 1'b0, "glitchStatus");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0000, 1'b0, "glitchPress");

    @(negedge clk);
    btn_left = 1'b1;
    holdCycles(10);
    applyStimulus(1'b0, 16'hFFF0, 16'h0, 1'b1, 16'h0001, 1'b0, "leftStatus");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0001, 1'b0, "leftPress");
    @(negedge clk);
    btn_left = 1'b0;
    holdCycles(10);
    applyStimulus(1'b0, 16'hFFF0, 16'h0, 1'b1, 16'h0000, 1'b0, "releaseStatus");

    @(negedge clk);
    btn_start = 1'b1;
    holdCycles(10);
    btn_start = 1'b0;
    holdCycles(10);
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0005, 1'b0, "pressBoth");
    applyStimulus(1'b1, 16'hFFF1, 16'h0001, 1'b0, 16'h0, 1'b0, "w1cLeft");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0004, 1'b0, "afterW1c");
    applyStimulus(1'b1, 16'hFFF1, 16'h0004, 1'b0, 16'h0, 1'b0, "w1cStart");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0000, 1'b0, "pressCleared");

    // Start's debounced rise lands on the same edge as the W1C write.
    @(negedge clk);
    btn_start = 1'b1;
    holdCycles(3);
    applyStimulus(1'b1, 16'hFFF1, 16'h0004, 1'b0, 16'h0, 1'b0, "setWinsWrite");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0004, 1'b0, "setWins");
    @(negedge clk);
    btn_start = 1'b0;
    holdCycles(10);

    // Asynchronous reset during a store's ACCESS cycle.
    @(negedge clk);
    req       = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h5A5A;
    @(posedge clk);
    #1;
    checkOutput("rstMid_weBefore", 16'(mem_we_b), 16'h1);
    req   = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("rstMid_memWe", 16'(mem_we_b), 16'h0);
    checkOutput("rstMid_busy", 16'(busy), 16'h0);
    checkOutput("rstMid_done", 16'(done), 16'h0);
    checkOutput("rstMid_led", led, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("rstHold_done", 16'(done), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstRelease_done", 16'(done), 16'h0);
    checkOutput("rstMid_memUntouched", mem[32], 16'h0000);
    checkOutput("rstMid_weCount", 16'(weCount), 16'h1);
    applyStimulus(1'b0, 16'h0010, 16'h0, 1'b1, 16'hBEEF, 1'b0, "postReset");
    applyStimulus(1'b0, 16'hFFF1, 16'h0, 1'b1, 16'h0000, 1'b0, "postResetPress");

    holdCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
